// File: rtl/fsm_step_sequencer_if.sv
// Host-side command and response handshake bundle for the FSM step sequencer.
interface fsm_step_sequencer_if #(
    parameter int GAP_W = 4,
    parameter int Q_W   = 3
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_d;
    logic [GAP_W-1:0] cmd_gap;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [Q_W-1:0]   rsp_q;

    modport master (
        output cmd_valid, cmd_d, cmd_gap, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_q
    );

    modport slave (
        input  cmd_valid, cmd_d, cmd_gap, rsp_ready,
        output cmd_ready, rsp_valid, rsp_q
    );
endinterface

// File: rtl/fsm_step_sequencer.sv
// Queues {d, gap} step commands, strobes the FSM once per command, waits the
// settle gap, then returns the sampled FSM q over a valid/ready response.
module fsm_step_sequencer #(
    parameter int DEPTH = 4,
    parameter int GAP_W = 4,
    parameter int Q_W   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    fsm_step_sequencer_if.slave  host,
    output logic                 fsm_d,
    output logic                 fsm_s,
    input  logic [Q_W-1:0]       fsm_q,
    output logic                 busy,
    output logic [7:0]           step_count
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, DRIVE, SETTLE, RESP} state_t;

    state_t           state;
    logic             mem_d   [DEPTH];
    logic [GAP_W-1:0] mem_gap [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic [GAP_W-1:0] cnt;
    logic             rsp_valid_r;
    logic [Q_W-1:0]   rsp_q_r;
    logic             full, empty, push, pop;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    // flush takes priority: a command offered in a flush cycle is discarded.
    assign push  = host.cmd_valid && !full && !flush;
    assign pop   = (state == IDLE) && !empty && !flush;

    assign host.cmd_ready = !full;
    assign host.rsp_valid = rsp_valid_r;
    assign host.rsp_q     = rsp_q_r;
    assign busy           = (state != IDLE) || !empty;

    // NOTE: payload storage has no reset; count alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_d[wr_ptr]   <= host.cmd_d;
            mem_gap[wr_ptr] <= host.cmd_gap;
        end
    end

    // NOTE: every clocked block uses non-blocking assignments so all state updates at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            fsm_d       <= 1'b0;
            fsm_s       <= 1'b0;
            cnt         <= '0;
            rsp_valid_r <= 1'b0;
            rsp_q_r     <= '0;
            step_count  <= 8'd0;
        end else if (flush) begin
            state       <= IDLE;
            fsm_s       <= 1'b0;
            rsp_valid_r <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!empty) begin
                        fsm_d <= mem_d[rd_ptr];
                        fsm_s <= 1'b1;
                        cnt   <= mem_gap[rd_ptr];
                        state <= DRIVE;
                    end
                end
                DRIVE: begin
                    fsm_s <= 1'b0;
                    state <= SETTLE;
                end
                SETTLE: begin
                    // cnt counts down through gap+1 settle cycles before q is sampled.
                    if (cnt == '0) begin
                        rsp_q_r     <= fsm_q;
                        rsp_valid_r <= 1'b1;
                        step_count  <= step_count + 8'd1;
                        state       <= RESP;
                    end else begin
                        cnt <= cnt - GAP_W'(1);
                    end
                end
                RESP: begin
                    if (host.rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
